// File: rtl/ram_arb_pkg.sv
// rtl/ram_arb_pkg.sv - shared types and constants for the 256x8 RAM arbiter
package ram_arb_pkg;

    localparam int ADDR_W    = 8;
    localparam int DATA_W    = 8;
    localparam int RAM_DEPTH = 256;

`ifdef RAM_ARB_CLEAR_EN
    typedef enum logic [1:0] {ST_INIT, ST_IDLE, ST_RUN} state_e;
    localparam state_e ST_RESET = ST_INIT;
`else
    typedef enum logic [1:0] {ST_IDLE, ST_RUN} state_e;
    localparam state_e ST_RESET = ST_IDLE;
`endif

    typedef enum logic [1:0] {TAG_NONE, TAG_CPU_RD, TAG_DMA_RD} tag_e;

    typedef struct packed {
        tag_e              tag;
        logic [ADDR_W-1:0] idx;
    } pipe_ent_t;

endpackage

// File: rtl/ram_arb_pipe.sv
// rtl/ram_arb_pipe.sv - two-stage read tag pipe and return-data steering
module ram_arb_pipe
    import ram_arb_pkg::*;
(
    input  logic              clk,
    input  logic              reset_n,
    input  pipe_ent_t         i_push,
    input  logic [DATA_W-1:0] i_ram_o,
    output logic              o_cpu_rd_inflight,
    output pipe_ent_t         o_s2,
    output logic              o_cpu_done,
    output logic [DATA_W-1:0] o_cpu_rdata,
    output logic              o_dma_valid,
    output logic [DATA_W-1:0] o_dma_data,
    output logic [ADDR_W-1:0] o_dma_index
);

    pipe_ent_t         r_s1;
    pipe_ent_t         r_s2;
    logic              r_cpu_done;
    logic [DATA_W-1:0] r_cpu_rdata;
    logic              r_dma_valid;
    logic [DATA_W-1:0] r_dma_data;
    logic [ADDR_W-1:0] r_dma_index;

    // Stage 2 lines up with ram_o: the RAM has captured the read issued two edges ago.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_s1        <= '0;
            r_s2        <= '0;
            r_cpu_done  <= 1'b0;
            r_cpu_rdata <= '0;
            r_dma_valid <= 1'b0;
            r_dma_data  <= '0;
            r_dma_index <= '0;
        end else begin
            r_s1        <= i_push;
            r_s2        <= r_s1;
            r_cpu_done  <= (r_s2.tag == TAG_CPU_RD);
            r_dma_valid <= (r_s2.tag == TAG_DMA_RD);
            if (r_s2.tag == TAG_CPU_RD) begin
                r_cpu_rdata <= i_ram_o;
            end
            if (r_s2.tag == TAG_DMA_RD) begin
                r_dma_data  <= i_ram_o;
                r_dma_index <= r_s2.idx;
            end
        end
    end

    assign o_cpu_rd_inflight = (r_s1.tag == TAG_CPU_RD) || (r_s2.tag == TAG_CPU_RD);
    assign o_s2              = r_s2;
    assign o_cpu_done        = r_cpu_done;
    assign o_cpu_rdata       = r_cpu_rdata;
    assign o_dma_valid       = r_dma_valid;
    assign o_dma_data        = r_dma_data;
    assign o_dma_index       = r_dma_index;

endmodule

// File: rtl/ram_arbiter_256x8.sv
// rtl/ram_arbiter_256x8.sv - CPU/DMA arbiter for a 256x8 sync RAM; RAM_ARB_CLEAR_EN adds a post-reset clear
module ram_arbiter_256x8
    import ram_arb_pkg::*;
#(
    parameter int DMA_MAX_RUN = 4
) (
    input  logic              clk,
    input  logic              reset_n,
    input  logic              cpu_req,
    input  logic              cpu_we,
    input  logic [ADDR_W-1:0] cpu_addr,
    input  logic [DATA_W-1:0] cpu_wdata,
    output logic              cpu_ack,
    output logic [DATA_W-1:0] cpu_rdata,
    input  logic              dma_start,
    input  logic [ADDR_W-1:0] dma_base,
    input  logic [ADDR_W-1:0] dma_len,
    output logic              dma_busy,
    output logic              dma_valid,
    output logic [DATA_W-1:0] dma_data,
    output logic [ADDR_W-1:0] dma_index,
    output logic              init_busy,
    output logic [ADDR_W-1:0] ram_a,
    output logic [DATA_W-1:0] ram_i,
    output logic              ram_r_n,
    output logic              ram_w_n,
    input  logic [DATA_W-1:0] ram_o
);

    localparam logic [7:0] MAX_RUN = 8'(DMA_MAX_RUN);

    state_e            r_state;
    state_e            w_state_nx;
    logic [ADDR_W-1:0] r_base;
    logic [ADDR_W-1:0] r_len;
    logic [ADDR_W:0]   r_issued;
    logic [7:0]        r_run_cnt;
    logic              r_wr_inflight;
    logic              r_wr_ack;
    logic [ADDR_W-1:0] r_ram_a;
    logic [DATA_W-1:0] r_ram_i;
    logic              r_ram_r_n;
    logic              r_ram_w_n;

    logic [ADDR_W:0]   w_len_eff;
    logic              w_cpu_rd_inflight;
    logic              w_cpu_cand;
    logic              w_dma_cand;
    logic              w_issue_cpu;
    logic              w_issue_dma;
    logic              w_in_init;
    logic              w_start;
    logic              w_last_ret;
    logic [ADDR_W-1:0] w_init_addr;
    pipe_ent_t         w_push;
    pipe_ent_t         w_s2;
    logic              w_cpu_done;

`ifdef RAM_ARB_CLEAR_EN
    logic [ADDR_W-1:0] r_init_addr;

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_init_addr <= '0;
        end else if (w_in_init) begin
            r_init_addr <= r_init_addr + 8'd1;
        end
    end
    assign w_init_addr = r_init_addr;
`else
    assign w_init_addr = '0;
`endif

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_state <= ST_RESET;
        end else begin
            r_state <= w_state_nx;
        end
    end

    always_comb begin
        w_state_nx = r_state;
        case (r_state)
`ifdef RAM_ARB_CLEAR_EN
            ST_INIT: if (w_init_addr == 8'hFF) w_state_nx = ST_IDLE;
`endif
            ST_IDLE: if (dma_start)  w_state_nx = ST_RUN;
            ST_RUN:  if (w_last_ret) w_state_nx = ST_IDLE;
            default: w_state_nx = ST_RESET;
        endcase
    end

    // The ack cycle itself blocks the CPU so a held cpu_req is not re-serviced.
    always_comb begin
`ifdef RAM_ARB_CLEAR_EN
        w_in_init = (r_state == ST_INIT);
`else
        w_in_init = 1'b0;
`endif
        w_start     = (r_state == ST_IDLE) && dma_start;
        w_len_eff   = (r_len == '0) ? 9'(RAM_DEPTH) : {1'b0, r_len};
        w_cpu_cand  = cpu_req && !w_cpu_rd_inflight && !r_wr_inflight && !cpu_ack && !w_in_init;
        w_dma_cand  = (r_state == ST_RUN) && (r_issued < w_len_eff);
        w_issue_dma = w_dma_cand && !(w_cpu_cand && (r_run_cnt >= MAX_RUN));
        w_issue_cpu = w_cpu_cand && !w_issue_dma;
        w_last_ret  = (w_s2.tag == TAG_DMA_RD) && (w_s2.idx == r_len - 8'd1);
        w_push      = '0;
        if (w_issue_dma) begin
            w_push.tag = TAG_DMA_RD;
            w_push.idx = r_issued[ADDR_W-1:0];
        end else if (w_issue_cpu && !cpu_we) begin
            w_push.tag = TAG_CPU_RD;
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_base        <= '0;
            r_len         <= '0;
            r_issued      <= '0;
            r_run_cnt     <= '0;
            r_wr_inflight <= 1'b0;
            r_wr_ack      <= 1'b0;
            r_ram_a       <= '0;
            r_ram_i       <= '0;
            r_ram_r_n     <= 1'b1;
            r_ram_w_n     <= 1'b1;
        end else begin
            r_wr_inflight <= w_issue_cpu && cpu_we;
            r_wr_ack      <= r_wr_inflight;

            if (w_start) begin
                r_base   <= dma_base;
                r_len    <= dma_len;
                r_issued <= '0;
            end else if (w_issue_dma) begin
                r_issued <= r_issued + 9'd1;
            end

            if (w_start || w_issue_cpu || !w_cpu_cand) begin
                r_run_cnt <= '0;
            end else if (w_issue_dma) begin
                r_run_cnt <= r_run_cnt + 8'd1;
            end

            r_ram_r_n <= 1'b1;
            r_ram_w_n <= 1'b1;
            if (w_in_init) begin
                r_ram_a   <= w_init_addr;
                r_ram_i   <= '0;
                r_ram_w_n <= 1'b0;
            end else if (w_issue_dma) begin
                r_ram_a   <= r_base + r_issued[ADDR_W-1:0];
                r_ram_r_n <= 1'b0;
            end else if (w_issue_cpu) begin
                r_ram_a <= cpu_addr;
                if (cpu_we) begin
                    r_ram_i   <= cpu_wdata;
                    r_ram_w_n <= 1'b0;
                end else begin
                    r_ram_r_n <= 1'b0;
                end
            end
        end
    end

    ram_arb_pipe u_pipe (
        .clk               (clk),
        .reset_n           (reset_n),
        .i_push            (w_push),
        .i_ram_o           (ram_o),
        .o_cpu_rd_inflight (w_cpu_rd_inflight),
        .o_s2              (w_s2),
        .o_cpu_done        (w_cpu_done),
        .o_cpu_rdata       (cpu_rdata),
        .o_dma_valid       (dma_valid),
        .o_dma_data        (dma_data),
        .o_dma_index       (dma_index)
    );

    assign cpu_ack   = w_cpu_done | r_wr_ack;
    assign dma_busy  = (r_state == ST_RUN);
    assign init_busy = w_in_init;
    assign ram_a     = r_ram_a;
    assign ram_i     = r_ram_i;
    assign ram_r_n   = r_ram_r_n;
    assign ram_w_n   = r_ram_w_n;

endmodule

// File: tb/tb_ram_arbiter_256x8.sv
// tb/tb_ram_arbiter_256x8.sv - self-checking bench for ram_arbiter_256x8
module tb_ram_arbiter_256x8;

    localparam int MAX_RUN = 4;
`ifdef RAM_ARB_CLEAR_EN
    localparam logic INIT_EXP = 1'b1;
`else
    localparam logic INIT_EXP = 1'b0;
`endif

    logic       clk = 1'b0;
    logic       reset_n = 1'b0;
    logic       cpu_req = 1'b0, cpu_we = 1'b0;
    logic [7:0] cpu_addr = '0, cpu_wdata = '0;
    logic       cpu_ack;
    logic [7:0] cpu_rdata;
    logic       dma_start = 1'b0;
    logic [7:0] dma_base = '0, dma_len = '0;
    logic       dma_busy, dma_valid, init_busy;
    logic [7:0] dma_data, dma_index;
    logic [7:0] ram_a, ram_i, ram_o;
    logic       ram_r_n, ram_w_n;

    ram_arbiter_256x8 #(.DMA_MAX_RUN(MAX_RUN)) dut (
        .clk(clk), .reset_n(reset_n),
        .cpu_req(cpu_req), .cpu_we(cpu_we), .cpu_addr(cpu_addr), .cpu_wdata(cpu_wdata),
        .cpu_ack(cpu_ack), .cpu_rdata(cpu_rdata),
        .dma_start(dma_start), .dma_base(dma_base), .dma_len(dma_len),
        .dma_busy(dma_busy), .dma_valid(dma_valid), .dma_data(dma_data), .dma_index(dma_index),
        .init_busy(init_busy),
        .ram_a(ram_a), .ram_i(ram_i), .ram_r_n(ram_r_n), .ram_w_n(ram_w_n), .ram_o(ram_o)
    );

    always #5 clk = ~clk;

    // Synchronous single-port RAM with registered read, and the expected-content shadow.
    logic [7:0] mem [256];
    logic [7:0] shadow [256];
    always @(posedge clk) begin
        if (!ram_w_n) mem[ram_a] <= ram_i;
        if (!ram_r_n) ram_o <= mem[ram_a];
    end

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    typedef struct { int c; logic busy; logic [7:0] idx; logic [7:0] data; } dv_t;
    dv_t        dq[$];
    logic [7:0] rd_log[$];
    int         ack_cnt = 0, wlow_cnt = 0;
    always @(negedge clk) begin
        if (dma_valid) dq.push_back('{cyc, dma_busy, dma_index, dma_data});
        if (!ram_r_n) rd_log.push_back(ram_a);
        if (cpu_ack) ack_cnt++;
        if (!ram_w_n) wlow_cnt++;
    end

    int total = 0, bad = 0;

    task automatic step();
        @(posedge clk); #1;
    endtask

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic check_reset_outs(input string tag);
        check({tag, "_strobes"}, {27'd0, cpu_ack, dma_valid, dma_busy, ram_r_n, ram_w_n}, 32'h3);
        check({tag, "_data"}, {cpu_rdata, dma_data, dma_index, ram_a}, 32'h0);
        check({tag, "_ram_i"}, {24'd0, ram_i}, 32'h0);
        check({tag, "_init_busy"}, {31'd0, init_busy}, {31'd0, INIT_EXP});
    endtask

    task automatic cpu_op(input logic we, input logic [7:0] a, input logic [7:0] d,
                          output logic [7:0] rd, output int lat);
        cpu_req = 1'b1; cpu_we = we; cpu_addr = a; cpu_wdata = d;
        lat = -1; rd = 'x;
        for (int i = 0; i < 40; i++) begin
            step();
            if (cpu_ack) begin lat = i; rd = cpu_rdata; break; end
        end
        cpu_req = 1'b0;
        if (we) shadow[a] = d;
        step();
    endtask

    task automatic wait_init();
        for (int i = 0; i < 400 && init_busy; i++) step();
        check("init_done", {31'd0, init_busy}, 32'd0);
    endtask

    task automatic wait_idle();
        for (int i = 0; i < 400 && dma_busy; i++) step();
        check("burst_end", {31'd0, dma_busy}, 32'd0);
        step();
    endtask

    task automatic burst(input logic [7:0] b, input logic [7:0] l, output int scyc);
        dq.delete();
        dma_start = 1'b1; dma_base = b; dma_len = l;
        step();
        dma_start = 1'b0; scyc = cyc;
        wait_idle();
    endtask

    task automatic check_burst(input logic [7:0] b, input int n, input int scyc, input bit contiguous);
        check("dma_count", dq.size(), n);
        for (int k = 0; k < dq.size() && k < n; k++) begin
            check("dma_index", {24'd0, dq[k].idx}, {24'd0, k[7:0]});
            check("dma_data", {24'd0, dq[k].data}, {24'd0, shadow[8'(b + k)]});
            check("dma_busy_at_valid", {31'd0, dq[k].busy}, {31'd0, k != n - 1});
        end
        if (contiguous && dq.size() == n) begin
            check("dma_first_latency", dq[0].c - scyc, 3);
            check("dma_back_to_back", dq[n-1].c - dq[0].c, n - 1);
        end
    endtask

    initial begin
        logic [7:0] rd, b, a, d, cb;
        int lat, scyc, w0, a0, n0, busy_cycles, got_ack;

`ifdef RAM_ARB_CLEAR_EN
        for (int n = 0; n < 256; n++) begin mem[n] = 8'hFF; shadow[n] = 8'h00; end
`else
        for (int n = 0; n < 256; n++) begin mem[n] = 8'(n); shadow[n] = 8'(n); end
`endif
        repeat (3) step();
        check_reset_outs("reset");
        reset_n = 1'b1;

        // Post-reset clear: CPU request must be held off for the whole clear.
        cpu_req = 1'b1; cpu_we = 1'b0; cpu_addr = 8'h00;
        a0 = ack_cnt;
        busy_cycles = init_busy ? 1 : 0;
        for (int i = 0; i < 400 && init_busy; i++) begin
            step();
            if (init_busy) busy_cycles++;
        end
        cpu_req = 1'b0;
        check("init_cycles", busy_cycles, INIT_EXP ? 256 : 0);
        check("init_no_ack", ack_cnt - a0, 0);
        step();
        cpu_op(1'b0, 8'h00, 8'h00, rd, lat);
        check("init_rd00", {24'd0, rd}, {24'd0, shadow[0]});
        cpu_op(1'b0, 8'hFF, 8'h00, rd, lat);
        check("init_rdFF", {24'd0, rd}, {24'd0, shadow[255]});

        // Directed CPU write then read.
        w0 = wlow_cnt;
        cpu_op(1'b1, 8'h10, 8'h5A, rd, lat);
        check("wr_latency", lat, 1);
        check("wr_strobe_cycles", wlow_cnt - w0, 1);
        cpu_op(1'b0, 8'h10, 8'h00, rd, lat);
        check("rd_latency", lat, 2);
        check("rd_data", {24'd0, rd}, 32'h5A);
        repeat (3) step();
        check("rdata_held", {24'd0, cpu_rdata}, 32'h5A);

        // Bursts over ram[n]=n, including address wrap and len=0.
        for (int n = 0; n < 256; n++) begin mem[n] = 8'(n); shadow[n] = 8'(n); end
        burst(8'hFE, 8'd4, scyc);
        check_burst(8'hFE, 4, scyc, 1'b1);
        b = 8'($urandom_range(0, 255));
        burst(b, 8'd0, scyc);
        check_burst(b, 256, scyc, 1'b1);

        // CPU held during a 16-byte burst: MAX_RUN DMA issues, then the CPU slot.
        b = 8'($urandom_range(0, 255));
        cb = b + 8'h80;
        rd_log.delete(); dq.delete();
        dma_start = 1'b1; dma_base = b; dma_len = 8'd16;
        step();
        dma_start = 1'b0; scyc = cyc;
        cpu_req = 1'b1; cpu_we = 1'b0; cpu_addr = cb;
        got_ack = 0; rd = 'x;
        for (int i = 0; i < 200 && dma_busy; i++) begin
            step();
            if (cpu_ack && cpu_req) begin rd = cpu_rdata; cpu_req = 1'b0; got_ack = 1; end
        end
        step();
        check("arb_cpu_ack", got_ack, 1);
        check("arb_cpu_rdata", {24'd0, rd}, {24'd0, shadow[cb]});
        check("arb_issue_count", rd_log.size(), 17);
        for (int k = 0; k < rd_log.size() && k < 17; k++) begin
            if (k < MAX_RUN) a = b + 8'(k);
            else if (k == MAX_RUN) a = cb;
            else a = b + 8'(k - 1);
            check("arb_issue_addr", {24'd0, rd_log[k]}, {24'd0, a});
        end
        check_burst(b, 16, scyc, 1'b0);

        // CPU write issued one edge before the DMA read of the same byte.
        b = 8'($urandom_range(0, 255));
        d = ~shadow[b];
        dq.delete();
        cpu_req = 1'b1; cpu_we = 1'b1; cpu_addr = b; cpu_wdata = d;
        dma_start = 1'b1; dma_base = b; dma_len = 8'd4;
        step();
        dma_start = 1'b0; scyc = cyc; shadow[b] = d;
        for (int i = 0; i < 20 && !cpu_ack; i++) step();
        check("hazard_wr_ack", {31'd0, cpu_ack}, 32'd1);
        cpu_req = 1'b0;
        wait_idle();
        check_burst(b, 4, scyc, 1'b1);

        // Randomized CPU traffic against the shadow.
        for (int t = 0; t < 24; t++) begin
            a = 8'($urandom_range(0, 15));
            d = 8'($urandom_range(0, 255));
            if ($urandom_range(0, 1) == 1) begin
                cpu_op(1'b1, a, d, rd, lat);
                check("rnd_wr_latency", lat, 1);
            end else begin
                cpu_op(1'b0, a, d, rd, lat);
                check("rnd_rd_latency", lat, 2);
                check("rnd_rd_data", {24'd0, rd}, {24'd0, shadow[a]});
            end
        end

        // Randomized bursts.
        for (int t = 0; t < 3; t++) begin
            b = 8'($urandom_range(0, 255));
            d = 8'($urandom_range(1, 40));
            burst(b, d, scyc);
            check_burst(b, int'(d), scyc, 1'b1);
        end

        // Reset with a CPU read and a DMA read both in flight.
        dq.delete();
        cpu_req = 1'b1; cpu_we = 1'b0; cpu_addr = 8'h33;
        dma_start = 1'b1; dma_base = 8'h40; dma_len = 8'd8;
        step();
        dma_start = 1'b0;
        step();
        a0 = ack_cnt; n0 = dq.size();
        reset_n = 1'b0; cpu_req = 1'b0;
        #1;
        check_reset_outs("midreset");
        repeat (3) step();
        reset_n = 1'b1;
        repeat (4) step();
        check("midreset_no_ack", ack_cnt - a0, 0);
        check("midreset_no_valid", dq.size() - n0, 0);
`ifdef RAM_ARB_CLEAR_EN
        for (int n = 0; n < 256; n++) shadow[n] = 8'h00;
`endif
        wait_init();
        cpu_op(1'b1, 8'h77, 8'hC3, rd, lat);
        cpu_op(1'b0, 8'h77, 8'h00, rd, lat);
        check("post_reset_rd", {24'd0, rd}, 32'hC3);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/ram_arbiter_256x8.md
# ram_arbiter_256x8

Arbiter and sequencer for one single-port 256x8 synchronous RAM with a registered read. It shares the RAM between two requesters. The first is a CPU-side port that makes single read/write accesses with a req/ack handshake. The second is a video-side DMA engine that streams a burst of consecutive bytes. The block owns every RAM control pin, issues at most one RAM operation per cycle, and tracks in-flight reads so that returned data reaches the correct requester.

## Interface
Parameters:
- DMA_MAX_RUN, default 4: number of consecutive DMA issues allowed while a CPU request waits; the CPU then gets one slot.

Ports:
- clk  in  1  system clock; all logic on its rising edge
- reset_n  in  1  asynchronous, active-low reset
- cpu_req  in  1  CPU access request; held until cpu_ack
- cpu_we  in  1  1 = write, 0 = read; stable while cpu_req is high
- cpu_addr  in  8  CPU byte address
- cpu_wdata  in  8  CPU write data
- cpu_ack  out  1  one-cycle pulse when the CPU access completes
- cpu_rdata  out  8  read data; valid with cpu_ack and held until the next CPU read completes
- dma_start  in  1  one-cycle pulse that starts a burst
- dma_base  in  8  burst start address, sampled on dma_start
- dma_len  in  8  burst length, sampled on dma_start; 0 means 256
- dma_busy  out  1  high from the dma_start edge until the last dma_valid
- dma_valid  out  1  DMA data strobe
- dma_data  out  8  DMA byte
- dma_index  out  8  offset of dma_data within the burst
- init_busy  out  1  RAM clear in progress (see Configuration)
- ram_a  out  8  RAM address
- ram_i  out  8  RAM write data
- ram_r_n  out  1  RAM read enable, active low
- ram_w_n  out  1  RAM write enable, active low
- ram_o  in  8  RAM read data; valid one edge after a read issue

## Operation
- States:
  - INIT: present only with the macro.
  - IDLE: no burst active.
  - RUN: burst active.
- dma_start in IDLE latches base and len, clears the index and run counter, and enters RUN. dma_start in RUN is ignored.
- Candidates at each edge:
  - CPU: cpu_req=1, no CPU operation in flight, and not the ack cycle. cpu_req sampled at the edge that ends the ack cycle is ignored.
  - DMA: in RUN with issued count < len.
- Priority: DMA wins. If the run counter has reached DMA_MAX_RUN and CPU is a candidate, CPU wins.
- Run counter: increments on each DMA issue while CPU is waiting; clears on a CPU issue or when CPU is not waiting.
- DMA address = (base + issued_count) mod 256; the address wraps 0xFF→0x00.
- Each issue pushes a tag into a 2-stage pipe. A tag is NONE, CPU_RD, or DMA_RD with its index. The stage-2 tag steers ram_o to cpu_rdata or dma_data.
- RUN → IDLE at the edge that registers the last dma_valid; dma_busy falls with it.
- A CPU write issued one cycle before a DMA read of the same address returns the new value.

## Timing
- ram_* outputs are registered.
  - Read issued at edge E0 means ram_r_n=0 after E0. The RAM captures at E1. The data is registered to the requester at E2.
  - CPU read: cpu_req first sampled at E0 gives cpu_ack and cpu_rdata after E2 (2-cycle latency).
  - CPU write: ram_w_n=0 after E0 and cpu_ack after E1.
- DMA streaming: reads issue back-to-back, one dma_valid per cycle, with a 2-cycle latency from the first issue.
- Idle cycles: ram_r_n=1, ram_w_n=1, ram_a and ram_i hold their last values.
- Reset values:
  - All strobes 0; ram_r_n=1, ram_w_n=1.
  - All data, address and index outputs 0x00.
  - State is INIT with the macro, IDLE without it.
- Reset mid-operation: in-flight operations are dropped, with no ack and no dma_valid.

## Configuration
- RAM_ARB_CLEAR_EN defined:
  - After reset, INIT writes 0x00 to addresses 0..255, one address per cycle (256 cycles).
  - init_busy=1 throughout INIT. cpu_req is not acked and dma_start is ignored.
  - INIT → IDLE after the write to 0xFF.
- RAM_ARB_CLEAR_EN undefined: init_busy is tied 0 and the INIT state is absent.

## Structure
- Package ram_arb_pkg holds:
  - the state enum;
  - the tag enum (NONE, CPU_RD, DMA_RD);
  - ADDR_W=8 and DATA_W=8;
  - the RAM depth constant, 256.
- Sub-module ram_arb_pipe: the 2-stage tag/index delay pipe and the return-data steering.

## Test plan
- CPU write 0x5A to 0x10, then CPU read 0x10 → write ack 1 cycle after the request; read ack 2 cycles after the request with cpu_rdata=0x5A; ram_w_n low for exactly 1 cycle.
- dma_base=0xFE, dma_len=4 over RAM preloaded with ram[n]=n → dma_valid on 4 consecutive cycles, data 0xFE,0xFF,0x00,0x01, index 0..3; dma_busy falls with the last valid.
- dma_len=0 → exactly 256 dma_valid, then dma_busy=0.
- cpu_req held during a 16-byte burst with DMA_MAX_RUN=4 → exactly 4 DMA issues precede the CPU slot; the remaining DMA data arrives in order with no index skipped.
- reset_n asserted while a CPU read and a DMA read are in flight → no cpu_ack and no dma_valid; all outputs return to their reset values immediately.
- With RAM_ARB_CLEAR_EN and ram pre-filled with 0xFF → init_busy high for 256 cycles with cpu_req unacked; afterwards reads of 0x00 and 0xFF return 0x00.
